pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline control unit that drives the hold and flush inputs of the PC, IF/ID and ID/EX pipeline registers. It detects load-use hazards, redirects on taken jumps/branches, and freezes the front end while a multi-cycle execute operation (MUL/DIV) completes. It sits beside the decode/execute stages and is the sole source of every stage-register hold/flush control.

## Interface
- `MaxWait`, 64: watchdog limit, in cycles, for a multi-cycle wait.
- `CntWidth`, 7: width of the wait counter; must satisfy 2^CntWidth > MaxWait.

- `Clk` in 1: clock; all state updates on rising edge.
- `Rst` in 1: synchronous, active-high reset.
- `IdRs1Addr` in 5: rs1 index of the instruction in ID.
- `IdRs2Addr` in 5: rs2 index of the instruction in ID.
- `IdRs1Read` in 1: ID instruction reads rs1.
- `IdRs2Read` in 1: ID instruction reads rs2.
- `ExRdAddr` in 5: rd of the instruction in EX (the ID/EX register output).
- `ExRdWriteEnable` in 1: EX instruction writes rd.
- `ExOpCode` in 7: opcode of the EX instruction.
- `ExJumpFlag` in 1: EX resolved a taken jump/branch this cycle.
- `ExJumpAddr` in 64: redirect target.
- `ExMultiStart` in 1: EX began a multi-cycle operation this cycle.
- `ExMultiDone` in 1: multi-cycle result is valid this cycle.
- `HoldPc` out 1: 1 = PC keeps its value.
- `HoldIf2Id` out 1: 1 = IF/ID keeps its value.
- `HoldId2Ex` out 1: 1 = ID/EX keeps its value.
- `FlushIf2Id` out 1: 1 = IF/ID loads NOP/reset values on the next edge.
- `FlushId2Ex` out 1: 1 = ID/EX loads NOP/reset values (bubble).
- `JumpFlagOut` out 1: PC loads `JumpAddrOut` on the next edge.
- `JumpAddrOut` out 64: redirect target to the PC.
- `WaitTimeout` out 1: sticky error, set when a wait exceeds `MaxWait`.
- `StallCycles` out 32: performance count of stall cycles (see Configuration).
- `FlushCount` out 32: performance count of redirects (see Configuration).

## Operation
- FSM states: RUN, WAIT. Reset state is RUN.
- All control outputs are combinational from state and inputs. While `Rst`=1, all outputs are 0.
- Flush overrides hold on the same register.
- RUN, priority high to low:
  - Jump: `ExJumpFlag`=1 → `JumpFlagOut`=1, `JumpAddrOut`=`ExJumpAddr`, `FlushIf2Id`=1, `FlushId2Ex`=1, all holds 0. Remain in RUN; any concurrent `ExMultiStart` is ignored.
  - Multi-start: `ExMultiStart`=1 → `HoldPc`=`HoldIf2Id`=`HoldId2Ex`=1. Next state WAIT, wait counter cleared to 0.
  - Load-use:
    - Condition: `ExOpCode`=7'b0000011, `ExRdWriteEnable`=1, `ExRdAddr`≠0, and (`IdRs1Read`∧`IdRs1Addr`=`ExRdAddr`) ∨ (`IdRs2Read`∧`IdRs2Addr`=`ExRdAddr`).
    - Response: `HoldPc`=1, `HoldIf2Id`=1, `FlushId2Ex`=1 for one cycle.
    - The bubble clears the condition on the next cycle, so no extra state is needed.
  - Otherwise all outputs are 0; `JumpAddrOut`=0 whenever `JumpFlagOut`=0.
- WAIT:
  - `HoldPc`, `HoldIf2Id` and `HoldId2Ex` stay 1; jump and load-use inputs are ignored.
  - Wait counter increments by 1 per cycle and saturates at `MaxWait`.
  - On `ExMultiDone`=1: all holds are 0 that cycle, next state RUN.
  - If the counter reaches `MaxWait` without `ExMultiDone`: set `WaitTimeout` (cleared only by `Rst`) and force a return to RUN with holds released.
- `ExMultiDone` seen in RUN is ignored.

## Timing
- Hazard, jump and hold responses are asserted in the same cycle as the triggering input; the stage registers act on the following edge.
- Load-use costs exactly 1 bubble cycle.
- A jump costs 2 flushed slots. The redirect is visible at the PC one edge after `ExJumpFlag`.
- A multi-cycle op stalls from the `ExMultiStart` cycle through the cycle before `ExMultiDone`; the done cycle itself is not held.
- `ExMultiStart` and `ExMultiDone` in the same RUN cycle: treated as start only (enter WAIT).
- Reset mid-WAIT returns the FSM to RUN and clears the counter on the next edge; no hold persists after `Rst` deasserts.

## Configuration
- Macro: `PIPE_CTRL_PERF_EN`.
- Defined:
  - `StallCycles` increments once per cycle with any hold asserted.
  - `FlushCount` increments once per cycle with `JumpFlagOut`=1.
  - Both counters wrap modulo 2^32 and reset to 0.
- Undefined: both outputs are constant 0 and no counter flops are built.

## Test plan
- Load-use: EX is `ld x5` (`ExOpCode`=0000011, `ExRdAddr`=5, `ExRdWriteEnable`=1), ID reads rs1=5 → one cycle of `HoldPc`=`HoldIf2Id`=`FlushId2Ex`=1, then all 0. Repeat with `ExRdAddr`=0 → no stall.
- Jump: `ExJumpFlag`=1, `ExJumpAddr`=0x8000_0040, with a load-use condition also present → `JumpFlagOut`=1, `JumpAddrOut`=0x8000_0040, both flushes 1, no holds.
- Multi-cycle: `ExMultiStart` pulse, `ExMultiDone` 5 cycles later → 5 cycles of all holds = 1, holds = 0 on the done cycle; `StallCycles` +5 with the macro defined.
- Timeout: `MaxWait`=8, `ExMultiStart` with no done → holds for 8 cycles, then `WaitTimeout`=1 (sticky), FSM back in RUN.
- Reset: `Rst`=1 for 1 cycle in the 3rd WAIT cycle → all outputs 0 immediately, RUN next cycle, counters 0, `WaitTimeout`=0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline hold/flush controller: load-use bubbles, jump redirects and front-end
// freeze during multi-cycle execute ops. Optional perf counters: PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int unsigned MaxWait  = 64,
  parameter int unsigned CntWidth = 7
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [4:0]  IdRs1Addr,
  input  logic [4:0]  IdRs2Addr,
  input  logic        IdRs1Read,
  input  logic        IdRs2Read,
  input  logic [4:0]  ExRdAddr,
  input  logic        ExRdWriteEnable,
  input  logic [6:0]  ExOpCode,
  input  logic        ExJumpFlag,
  input  logic [63:0] ExJumpAddr,
  input  logic        ExMultiStart,
  input  logic        ExMultiDone,
  output logic        HoldPc,
  output logic        HoldIf2Id,
  output logic        HoldId2Ex,
  output logic        FlushIf2Id,
  output logic        FlushId2Ex,
  output logic        JumpFlagOut,
  output logic [63:0] JumpAddrOut,
  output logic        WaitTimeout,
  output logic [31:0] StallCycles,
  output logic [31:0] FlushCount,
  output logic        DbgState
);

  // Handshake: ExMultiStart is a one-cycle request; ExMultiDone is a one-cycle
  // completion strobe honoured only in WAIT. Holds are the back-pressure response.

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam logic [6:0]          OpLoad = 7'b0000011;
  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxWait);

  state_e              state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d, cnt_inc;
  logic                timeout_q, timeout_d;
  logic                load_use;
  logic                hold_pc, hold_if, hold_ex;
  logic                flush_if, flush_ex;
  logic                jump_flag;
  logic [63:0]         jump_addr;

  assign load_use = (ExOpCode == OpLoad) && ExRdWriteEnable && (ExRdAddr != 5'd0) &&
                    ((IdRs1Read && (IdRs1Addr == ExRdAddr)) ||
                     (IdRs2Read && (IdRs2Addr == ExRdAddr)));

  assign cnt_inc = (cnt_q == MaxCnt) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    hold_pc   = 1'b0;
    hold_if   = 1'b0;
    hold_ex   = 1'b0;
    flush_if  = 1'b0;
    flush_ex  = 1'b0;
    jump_flag = 1'b0;
    jump_addr = '0;
    if (!Rst) begin
      unique case (state_q)
        RUN: begin
          if (ExJumpFlag) begin
            jump_flag = 1'b1;
            jump_addr = ExJumpAddr;
            flush_if  = 1'b1;
            flush_ex  = 1'b1;
          end else if (ExMultiStart) begin
            hold_pc = 1'b1;
            hold_if = 1'b1;
            hold_ex = 1'b1;
            state_d = WAIT;
            cnt_d   = '0;
          end else if (load_use) begin
            hold_pc  = 1'b1;
            hold_if  = 1'b1;
            flush_ex = 1'b1;
          end
        end
        WAIT: begin
          cnt_d = cnt_inc;
          if (ExMultiDone) begin
            state_d = RUN;
          end else if (cnt_inc == MaxCnt) begin
            // Watchdog expired: release the pipe this cycle and flag the error.
            state_d   = RUN;
            timeout_d = 1'b1;
          end else begin
            hold_pc = 1'b1;
            hold_if = 1'b1;
            hold_ex = 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // A flush always wins over a hold on the same stage register.
  assign HoldPc      = hold_pc;
  assign HoldIf2Id   = hold_if & ~flush_if;
  assign HoldId2Ex   = hold_ex & ~flush_ex;
  assign FlushIf2Id  = flush_if;
  assign FlushId2Ex  = flush_ex;
  assign JumpFlagOut = jump_flag;
  assign JumpAddrOut = jump_addr;
  assign WaitTimeout = timeout_q & ~Rst;
  assign DbgState    = state_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_q, flushcnt_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      stall_q    <= '0;
      flushcnt_q <= '0;
    end else begin
      if (HoldPc || HoldIf2Id || HoldId2Ex) stall_q <= stall_q + 32'd1;
      if (JumpFlagOut) flushcnt_q <= flushcnt_q + 32'd1;
    end
  end

  assign StallCycles = stall_q;
  assign FlushCount  = flushcnt_q;
`else
  assign StallCycles = 32'd0;
  assign FlushCount  = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (MaxWait=8) covering load-use, jump, multi-cycle
// wait, watchdog timeout and reset mid-wait.
module tb_pipe_ctrl;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [4:0]  IdRs1Addr, IdRs2Addr, ExRdAddr;
  logic        IdRs1Read, IdRs2Read, ExRdWriteEnable;
  logic [6:0]  ExOpCode;
  logic        ExJumpFlag, ExMultiStart, ExMultiDone;
  logic [63:0] ExJumpAddr;
  logic        HoldPc, HoldIf2Id, HoldId2Ex, FlushIf2Id, FlushId2Ex, JumpFlagOut;
  logic [63:0] JumpAddrOut;
  logic        WaitTimeout, DbgState;
  logic [31:0] StallCycles, FlushCount;

  int vectors = 0;
  int miscompares = 0;

`ifdef PIPE_CTRL_PERF_EN
  localparam bit Perf = 1'b1;
`else
  localparam bit Perf = 1'b0;
`endif

  // Control bundle order: HoldPc HoldIf2Id HoldId2Ex FlushIf2Id FlushId2Ex JumpFlagOut
  localparam logic [5:0] Idle     = 6'b000000;
  localparam logic [5:0] LoadUse  = 6'b110010;
  localparam logic [5:0] JumpCtl  = 6'b000111;
  localparam logic [5:0] HoldAll  = 6'b111000;

  pipe_ctrl #(.MaxWait(8), .CntWidth(4)) dut (
    .Clk(Clk), .Rst(Rst),
    .IdRs1Addr(IdRs1Addr), .IdRs2Addr(IdRs2Addr),
    .IdRs1Read(IdRs1Read), .IdRs2Read(IdRs2Read),
    .ExRdAddr(ExRdAddr), .ExRdWriteEnable(ExRdWriteEnable), .ExOpCode(ExOpCode),
    .ExJumpFlag(ExJumpFlag), .ExJumpAddr(ExJumpAddr),
    .ExMultiStart(ExMultiStart), .ExMultiDone(ExMultiDone),
    .HoldPc(HoldPc), .HoldIf2Id(HoldIf2Id), .HoldId2Ex(HoldId2Ex),
    .FlushIf2Id(FlushIf2Id), .FlushId2Ex(FlushId2Ex),
    .JumpFlagOut(JumpFlagOut), .JumpAddrOut(JumpAddrOut),
    .WaitTimeout(WaitTimeout), .StallCycles(StallCycles), .FlushCount(FlushCount),
    .DbgState(DbgState)
  );

  // Clock / reset
  always #5 Clk = ~Clk;

  // Driver tasks
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    IdRs1Addr = 5'd0; IdRs2Addr = 5'd0; IdRs1Read = 1'b0; IdRs2Read = 1'b0;
    ExRdAddr = 5'd0; ExRdWriteEnable = 1'b0; ExOpCode = 7'd0;
    ExJumpFlag = 1'b0; ExJumpAddr = 64'd0; ExMultiStart = 1'b0; ExMultiDone = 1'b0;
  endtask

  task automatic drive_ld(input logic [4:0] rd, input logic [4:0] rs1, input logic r1,
                          input logic [4:0] rs2, input logic r2);
    ExOpCode = 7'b0000011; ExRdWriteEnable = 1'b1; ExRdAddr = rd;
    IdRs1Addr = rs1; IdRs1Read = r1; IdRs2Addr = rs2; IdRs2Read = r2;
  endtask

  // Checkers
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [5:0] exp);
    #1;
    chk(tag, {58'd0, HoldPc, HoldIf2Id, HoldId2Ex, FlushIf2Id, FlushId2Ex, JumpFlagOut},
        {58'd0, exp});
  endtask

  initial begin
    idle_inputs();
    Rst = 1'b1;
    tick(); tick();

    // Reset: outputs forced low even with a jump request present
    ExJumpFlag = 1'b1; ExJumpAddr = 64'h1234;
    chk_ctl("rst_ctl", Idle);
    chk("rst_jaddr", JumpAddrOut, 64'd0);
    chk("rst_timeout", {63'd0, WaitTimeout}, 64'd0);
    chk("rst_state", {63'd0, DbgState}, 64'd0);
    chk("rst_stall", {32'd0, StallCycles}, 64'd0);
    chk("rst_flushcnt", {32'd0, FlushCount}, 64'd0);
    idle_inputs();
    Rst = 1'b0;
    tick();

    // Load-use via rs1, then bubble clears it
    drive_ld(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    chk_ctl("lu_rs1", LoadUse);
    tick(); idle_inputs();
    chk_ctl("lu_after", Idle);
    tick();
    drive_ld(5'd7, 5'd3, 1'b1, 5'd7, 1'b1);
    chk_ctl("lu_rs2", LoadUse);
    tick(); idle_inputs();
    drive_ld(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    chk_ctl("lu_rd0", Idle);
    drive_ld(5'd5, 5'd5, 1'b0, 5'd5, 1'b0);
    chk_ctl("lu_noread", Idle);
    drive_ld(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    ExRdWriteEnable = 1'b0;
    chk_ctl("lu_nowe", Idle);
    drive_ld(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    ExOpCode = 7'b0110011;
    chk_ctl("lu_notload", Idle);

    // Jump beats load-use and a concurrent multi-start
    drive_ld(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    ExJumpFlag = 1'b1; ExJumpAddr = 64'h8000_0040; ExMultiStart = 1'b1;
    chk_ctl("jump_ctl", JumpCtl);
    chk("jump_addr", JumpAddrOut, 64'h8000_0040);
    tick(); idle_inputs();
    chk_ctl("jump_after", Idle);
    chk("jump_state", {63'd0, DbgState}, 64'd0);
    chk("jump_addr0", JumpAddrOut, 64'd0);
    chk("flushcnt", {32'd0, FlushCount}, Perf ? 64'd1 : 64'd0);

    // Done in RUN is ignored
    ExMultiDone = 1'b1;
    chk_ctl("done_in_run", Idle);
    tick(); idle_inputs();
    chk("done_in_run_st", {63'd0, DbgState}, 64'd0);

    // Multi-cycle: start+done together is start only; done 5 cycles later
    ExMultiStart = 1'b1; ExMultiDone = 1'b1;
    chk_ctl("mul_start", HoldAll);
    tick(); idle_inputs();
    for (int i = 1; i <= 4; i++) begin
      ExJumpFlag = 1'b1; ExJumpAddr = 64'hdead;
      drive_ld(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
      chk_ctl($sformatf("mul_wait%0d", i), HoldAll);
      chk($sformatf("mul_wait%0d_st", i), {63'd0, DbgState}, 64'd1);
      tick(); idle_inputs();
    end
    ExMultiDone = 1'b1;
    chk_ctl("mul_done", Idle);
    tick(); idle_inputs();
    chk_ctl("mul_after", Idle);
    chk("mul_state", {63'd0, DbgState}, 64'd0);
    chk("stall_mul", {32'd0, StallCycles}, Perf ? 64'd7 : 64'd0);

    // Watchdog: 8 held cycles, then release with sticky timeout
    ExMultiStart = 1'b1;
    chk_ctl("to_start", HoldAll);
    tick(); idle_inputs();
    for (int i = 1; i <= 7; i++) begin
      chk_ctl($sformatf("to_wait%0d", i), HoldAll);
      tick();
    end
    chk_ctl("to_release", Idle);
    chk("to_pre_flag", {63'd0, WaitTimeout}, 64'd0);
    tick();
    chk("to_flag", {63'd0, WaitTimeout}, 64'd1);
    chk("to_state", {63'd0, DbgState}, 64'd0);
    chk_ctl("to_after", Idle);
    tick();
    chk("to_sticky", {63'd0, WaitTimeout}, 64'd1);
    chk("stall_to", {32'd0, StallCycles}, Perf ? 64'd15 : 64'd0);

    // Reset in the third WAIT cycle
    ExMultiStart = 1'b1;
    tick(); idle_inputs();
    tick();
    chk_ctl("rw_wait2", HoldAll);
    tick();
    Rst = 1'b1;
    chk_ctl("rw_rst_ctl", Idle);
    chk("rw_rst_to", {63'd0, WaitTimeout}, 64'd0);
    tick();
    Rst = 1'b0;
    chk_ctl("rw_after", Idle);
    chk("rw_state", {63'd0, DbgState}, 64'd0);
    chk("rw_timeout", {63'd0, WaitTimeout}, 64'd0);
    chk("rw_stall", {32'd0, StallCycles}, 64'd0);
    chk("rw_flushcnt", {32'd0, FlushCount}, 64'd0);
    tick();
    chk_ctl("rw_idle", Idle);

    // Report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
